// File: rtl/alu_seq_exec_if.sv
// Handshake/result bundle between the decode stage and the multi-cycle ALU.
// The core drives the master side; the execution unit sits on the slave side.
interface alu_seq_exec_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   opcode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic [5:0]       flags;

  modport master (
    output in_valid, opcode, op_a, op_b, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, flags
  );

  modport slave (
    input  in_valid, opcode, op_a, op_b, out_ready,
    output in_ready, out_valid, result_lo, result_hi, flags
  );
endinterface

// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU: single-cycle logic/add/shift ops, iterative shift-add MUL and
// restoring DIV, valid/ready on both sides. Flags are {ILL,DZ,V,C,N,Z}.
module alu_seq_exec #(
  parameter int WIDTH = 16,
  parameter int OPW   = 6
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_exec_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(6'h04);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6'h05);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(6'h06);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(6'h07);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(6'h08);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6'h09);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(6'h0A);
  localparam logic [OPW-1:0] OP_NAND = OPW'(6'h0B);
  localparam logic [OPW-1:0] OP_NOR  = OPW'(6'h0C);
  localparam logic [OPW-1:0] OP_XNOR = OPW'(6'h0D);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(6'h0E);
  localparam logic [OPW-1:0] OP_LLSH = OPW'(6'h0F);
  localparam logic [OPW-1:0] OP_LRSH = OPW'(6'h10);
  localparam logic [OPW-1:0] OP_AND  = OPW'(6'h11);
  localparam logic [OPW-1:0] OP_ARSH = OPW'(6'h12);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  typedef struct packed {
    logic [5:0]       flg;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } res_t;

  // Everything except MUL and a non-zero DIV finishes in the accept cycle.
  function automatic res_t exec_simple(input logic [OPW-1:0] op,
                                       input logic [WIDTH-1:0] a,
                                       input logic [WIDTH-1:0] b);
    res_t               r;
    logic [WIDTH:0]     ext;
    logic signed [WIDTH:0] sx;
    logic               c, v, ill, dz;
    r   = '0;
    ext = '0;
    sx  = '0;
    c   = 1'b0;
    v   = 1'b0;
    ill = 1'b0;
    dz  = 1'b0;
    case (op)
      OP_ADD: begin
        ext  = {1'b0, a} + {1'b0, b};
        r.lo = ext[WIDTH-1:0];
        c    = ext[WIDTH];
        v    = (a[WIDTH-1] == b[WIDTH-1]) && (r.lo[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        ext  = {1'b0, a} - {1'b0, b};
        r.lo = ext[WIDTH-1:0];
        c    = ext[WIDTH];
        v    = (a[WIDTH-1] != b[WIDTH-1]) && (r.lo[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NEG: begin
        r.lo = '0 - a;
        v    = (a == {1'b1, {(WIDTH-1){1'b0}}});
        c    = |a;
      end
      OP_DIV: begin
        r.lo = '1;
        r.hi = a;
        dz   = 1'b1;
      end
      OP_OR:   r.lo = a | b;
      OP_XOR:  r.lo = a ^ b;
      OP_NAND: r.lo = ~(a & b);
      OP_NOR:  r.lo = ~(a | b);
      OP_XNOR: r.lo = ~(a ^ b);
      OP_NOT:  r.lo = ~a;
      OP_AND:  r.lo = a & b;
      // An extra guard bit catches the last bit shifted out.
      OP_LLSH: begin
        ext  = {1'b0, a} << b;
        r.lo = ext[WIDTH-1:0];
        c    = ext[WIDTH];
      end
      OP_LRSH: begin
        ext  = {a, 1'b0} >> b;
        r.lo = ext[WIDTH:1];
        c    = ext[0];
      end
      OP_ARSH: begin
        sx   = $signed({a, 1'b0}) >>> b;
        r.lo = sx[WIDTH:1];
        c    = sx[0];
      end
      default: ill = 1'b1;
    endcase
    r.flg = {ill, dz, v, c, r.lo[WIDTH-1], ~|r.lo};
    return r;
  endfunction

  function automatic logic [5:0] iter_flags(input logic is_mul,
                                            input logic [WIDTH-1:0] hi,
                                            input logic [WIDTH-1:0] lo);
    logic cv;
    cv = is_mul & (|hi);
    return {2'b00, cv, cv, lo[WIDTH-1], ~|lo};
  endfunction

  state_t             st_q;
  logic [SHW-1:0]     cnt_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   res_lo_q, res_hi_q;
  logic [5:0]         flags_q;
  logic [2*WIDTH-1:0] work_q;
  logic [WIDTH-1:0]   opd_q;

  logic               in_ready_d, accept_d, last_d;
  res_t               simple_d;
  logic [WIDTH:0]     mul_sum_d, div_sh_d, div_diff_d;
  logic [2*WIDTH-1:0] mul_d, div_d;

  assign in_ready_d = (st_q == S_IDLE) | ((st_q == S_DONE) & bus.out_ready);
  assign accept_d   = bus.in_valid & in_ready_d;
  assign last_d     = (cnt_q == SHW'(WIDTH-1));
  assign simple_d   = exec_simple(bus.opcode, bus.op_a, bus.op_b);

  // MUL: work = {partial product high, remaining multiplier bits}.
  assign mul_sum_d = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                   + (work_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
  assign mul_d     = {mul_sum_d, work_q[WIDTH-1:1]};

  // DIV: work = {partial remainder, dividend shifting into quotient}.
  assign div_sh_d   = work_q[2*WIDTH-1:WIDTH-1];
  assign div_diff_d = div_sh_d - {1'b0, opd_q};
  assign div_d      = div_diff_d[WIDTH]
                    ? {div_sh_d[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                    : {div_diff_d[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      flags_q     <= '0;
    end else begin
      case (st_q)
        S_MUL: begin
          work_q <= mul_d;
          cnt_q  <= cnt_q + 1'b1;
          if (last_d) begin
            st_q        <= S_DONE;
            out_valid_q <= 1'b1;
            res_hi_q    <= mul_d[2*WIDTH-1:WIDTH];
            res_lo_q    <= mul_d[WIDTH-1:0];
            flags_q     <= iter_flags(1'b1, mul_d[2*WIDTH-1:WIDTH], mul_d[WIDTH-1:0]);
          end
        end
        S_DIV: begin
          work_q <= div_d;
          cnt_q  <= cnt_q + 1'b1;
          if (last_d) begin
            st_q        <= S_DONE;
            out_valid_q <= 1'b1;
            res_hi_q    <= div_d[2*WIDTH-1:WIDTH];
            res_lo_q    <= div_d[WIDTH-1:0];
            flags_q     <= iter_flags(1'b0, div_d[2*WIDTH-1:WIDTH], div_d[WIDTH-1:0]);
          end
        end
        default: begin
          // IDLE, or DONE where a taken result may be replaced on the same edge.
          if (accept_d) begin
            cnt_q <= '0;
            if (bus.opcode == OP_MUL) begin
              st_q        <= S_MUL;
              out_valid_q <= 1'b0;
              work_q      <= {{WIDTH{1'b0}}, bus.op_b};
              opd_q       <= bus.op_a;
            end else if ((bus.opcode == OP_DIV) && (bus.op_b != '0)) begin
              st_q        <= S_DIV;
              out_valid_q <= 1'b0;
              work_q      <= {{WIDTH{1'b0}}, bus.op_a};
              opd_q       <= bus.op_b;
            end else begin
              st_q        <= S_DONE;
              out_valid_q <= 1'b1;
              res_lo_q    <= simple_d.lo;
              res_hi_q    <= simple_d.hi;
              flags_q     <= simple_d.flg;
            end
          end else if ((st_q == S_DONE) && bus.out_ready) begin
            st_q        <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_d;
  assign bus.out_valid = out_valid_q;
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec (WIDTH=16): directed vectors, a transaction-level
// reference model checked every cycle, plus hand-computed literal expectations.
module tb_alu_seq_exec;

  localparam int W = 16;
  localparam int M = (1 << W) - 1;
  localparam int H = 1 << (W - 1);

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 0;

  alu_seq_exec_if #(.WIDTH(W), .OPW(6)) bif ();

  alu_seq_exec #(.WIDTH(W), .OPW(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int lo;
    int hi;
    int fl;
    int lat;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= H) ? x - (1 << W) : x;
  endfunction

  // Reference result straight from the operation definitions.
  function automatic exp_t ref_op(input int op, input int a, input int b);
    exp_t e;
    int s, sa, sb;
    longint p;
    bit c, v, ill, dz;
    e.lo = 0; e.hi = 0; e.lat = 1;
    c = 0; v = 0; ill = 0; dz = 0;
    sa = sgn(a); sb = sgn(b);
    case (op)
      'h04: begin s = a + b; e.lo = s & M; c = (s > M); v = (sa + sb > H - 1) || (sa + sb < -H); end
      'h05: begin e.lo = (a - b) & M; c = (a < b); v = (sa - sb > H - 1) || (sa - sb < -H); end
      'h06: begin e.lo = (-a) & M; v = (a == H); c = (a != 0); end
      'h07: begin
        p = longint'(a) * longint'(b);
        e.lo = int'(p & M); e.hi = int'((p >> W) & M);
        c = (e.hi != 0); v = c; e.lat = W + 1;
      end
      'h08: begin
        if (b == 0) begin e.lo = M; e.hi = a; dz = 1; end
        else begin e.lo = a / b; e.hi = a % b; e.lat = W + 1; end
      end
      'h09: e.lo = a | b;
      'h0A: e.lo = a ^ b;
      'h0B: e.lo = ~(a & b) & M;
      'h0C: e.lo = ~(a | b) & M;
      'h0D: e.lo = ~(a ^ b) & M;
      'h0E: e.lo = ~a & M;
      'h11: e.lo = a & b;
      'h0F: begin
        if (b == 0) e.lo = a;
        else if (b <= W) begin e.lo = (a << b) & M; c = (a >> (W - b)) & 1; end
      end
      'h10: begin
        if (b == 0) e.lo = a;
        else if (b <= W) begin e.lo = a >> b; c = (a >> (b - 1)) & 1; end
      end
      'h12: begin
        if (b == 0) e.lo = a;
        else if (b < W) begin e.lo = (sa >>> b) & M; c = (a >> (b - 1)) & 1; end
        else begin e.lo = (a >= H) ? M : 0; c = (a >= H); end
      end
      default: ill = 1;
    endcase
    e.fl = (int'(ill) << 5) | (int'(dz) << 4) | (int'(v) << 3) | (int'(c) << 2)
         | (((e.lo >> (W - 1)) & 1) << 1) | int'(e.lo == 0);
    return e;
  endfunction

  // Model: one result in flight; m_wait counts edges until it is presented.
  bit   m_pend = 0;
  int   m_wait = 0;
  exp_t m_exp;

  always @(posedge clk) begin : model
    bit   rdy;
    exp_t e;
    if (rst) begin
      m_pend = 0;
    end else begin
      rdy = !m_pend || (m_wait == 0 && bif.out_ready);
      if (m_pend && m_wait == 0 && bif.out_ready) m_pend = 0;
      else if (m_pend && m_wait > 0) m_wait--;
      if (bif.in_valid && rdy) begin
        e      = ref_op(int'(bif.opcode), int'(bif.op_a), int'(bif.op_b));
        m_exp  = e;
        m_pend = 1;
        m_wait = e.lat - 1;
      end
    end
  end

  always @(negedge clk) begin : compare
    bit ev, er;
    if (chk_en) begin
      ev = m_pend && (m_wait == 0);
      er = !m_pend || (ev && bif.out_ready);
      chk("cyc_out_valid", 32'(bif.out_valid), 32'(ev));
      chk("cyc_in_ready", 32'(bif.in_ready), 32'(er));
      if (ev) begin
        chk("cyc_lo", 32'(bif.result_lo), m_exp.lo);
        chk("cyc_hi", 32'(bif.result_hi), m_exp.hi);
        chk("cyc_flags", 32'(bif.flags), m_exp.fl);
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    bit r;
    int n;
    bif.in_valid = 1'b1; bif.opcode = op; bif.op_a = a; bif.op_b = b;
    r = 0; n = 0;
    while (!r && n < 200) begin
      @(negedge clk); r = bif.in_ready;
      @(posedge clk); #1; n++;
    end
    bif.in_valid = 1'b0;
    if (!r) chk("issue_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (bif.out_valid !== 1'b1 && lat < 100) begin
      step(); lat++;
    end
  endtask

  int   lat;
  exp_t e;

  logic [5:0]  t_op [14] = '{6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h11, 6'h04, 6'h05,
                             6'h10, 6'h12, 6'h12, 6'h0F, 6'h10, 6'h0F};
  logic [15:0] t_a  [14] = '{16'h00FF, 16'hFFFF, 16'h0000, 16'h1234, 16'h1234, 16'hF0F0, 16'hFFFF, 16'h8000,
                             16'h8001, 16'h8000, 16'h8000, 16'h1234, 16'h0003, 16'hFFFF};
  logic [15:0] t_b  [14] = '{16'h0F0F, 16'hFFFF, 16'h0000, 16'h00FF, 16'h0000, 16'hFF00, 16'h0001, 16'h0001,
                             16'h0010, 16'h0020, 16'h0004, 16'h0000, 16'h0001, 16'h0011};

  initial begin
    rst = 1'b1;
    bif.in_valid = 1'b0; bif.opcode = '0; bif.op_a = '0; bif.op_b = '0;
    bif.out_ready = 1'b1;

    // Model sanity against hand arithmetic.
    e = ref_op('h07, 'hFFFF, 'hFFFF);
    chk("model_mul_hi", e.hi, 'hFFFE);
    chk("model_mul_lo", e.lo, 'h0001);
    e = ref_op('h12, 'h8000, 'h0004);
    chk("model_arsh", e.lo, 'hF800);

    step();
    chk_en = 1;
    step();
    chk("rst_out_valid", 32'(bif.out_valid), 0);
    chk("rst_in_ready", 32'(bif.in_ready), 1);
    chk("rst_lo", 32'(bif.result_lo), 0);
    chk("rst_hi", 32'(bif.result_hi), 0);
    chk("rst_flags", 32'(bif.flags), 0);
    rst = 1'b0;
    step();

    issue(6'h04, 16'h7FFF, 16'h0001); wait_valid(lat);
    chk("add_lat", lat, 1);
    chk("add_lo", 32'(bif.result_lo), 'h8000);
    chk("add_hi", 32'(bif.result_hi), 0);
    chk("add_flags", 32'(bif.flags), 'h0A);
    step();

    issue(6'h05, 16'h0003, 16'h0005); wait_valid(lat);
    chk("sub_lo", 32'(bif.result_lo), 'hFFFE);
    chk("sub_flags", 32'(bif.flags), 'h06);
    step();

    issue(6'h06, 16'h8000, 16'h0000); wait_valid(lat);
    chk("neg_lo", 32'(bif.result_lo), 'h8000);
    chk("neg_flags", 32'(bif.flags), 'h0E);
    step();

    issue(6'h07, 16'hFFFF, 16'hFFFF); wait_valid(lat);
    chk("mul_lat", lat, 17);
    chk("mul_hi", 32'(bif.result_hi), 'hFFFE);
    chk("mul_lo", 32'(bif.result_lo), 'h0001);
    chk("mul_flags", 32'(bif.flags), 'h0C);
    step();

    issue(6'h08, 16'h0064, 16'h0007); wait_valid(lat);
    chk("div_lat", lat, 17);
    chk("div_lo", 32'(bif.result_lo), 'h000E);
    chk("div_hi", 32'(bif.result_hi), 'h0002);
    step();

    issue(6'h08, 16'h0005, 16'h0000); wait_valid(lat);
    chk("dz_lat", lat, 1);
    chk("dz_lo", 32'(bif.result_lo), 'hFFFF);
    chk("dz_hi", 32'(bif.result_hi), 'h0005);
    chk("dz_flags", 32'(bif.flags), 'h12);
    step();

    // Consumer stalls while a new op waits; it must be taken on the release edge.
    bif.out_ready = 1'b0;
    issue(6'h04, 16'h0001, 16'h0002); wait_valid(lat);
    bif.in_valid = 1'b1; bif.opcode = 6'h09; bif.op_a = 16'h00F0; bif.op_b = 16'h0F00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_lo", 32'(bif.result_lo), 'h0003);
      chk("bp_valid", 32'(bif.out_valid), 1);
      chk("bp_in_ready", 32'(bif.in_ready), 0);
    end
    bif.out_ready = 1'b1;
    step();
    bif.in_valid = 1'b0;
    chk("b2b_valid", 32'(bif.out_valid), 1);
    chk("b2b_lo", 32'(bif.result_lo), 'h0FF0);
    step();

    issue(6'h0F, 16'h8001, 16'h0001); wait_valid(lat);
    chk("llsh_lo", 32'(bif.result_lo), 'h0002);
    chk("llsh_flags", 32'(bif.flags), 'h04);
    step();

    for (int i = 0; i < 14; i++) begin
      issue(t_op[i], t_a[i], t_b[i]); wait_valid(lat);
      e = ref_op(int'(t_op[i]), int'(t_a[i]), int'(t_b[i]));
      chk("vec_lat", lat, e.lat);
      step();
    end

    // Reset lands on the 8th MUL iteration edge.
    issue(6'h07, 16'h1234, 16'h5678);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", 32'(bif.in_ready), 1);
    chk("abort_lo", 32'(bif.result_lo), 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("abort_valid", 32'(bif.out_valid), 0);
    end

    issue(6'h3F, 16'h1111, 16'h2222); wait_valid(lat);
    chk("ill_lo", 32'(bif.result_lo), 0);
    chk("ill_hi", 32'(bif.result_hi), 0);
    chk("ill_flags", 32'(bif.flags), 'h21);
    step();

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
